// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder and its RAM array.
package mem_pkg;

   localparam int DATA_W     = 8;
   localparam int CPU_ADDR_W = 16;

   // Responder FSM states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DONE    = 2'd2,
      RELEASE = 2'd3
   } state_e;

   // Kind of access latched at request time
   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } kind_e;

   // True when any CPU address bit above the implemented range is set
   function automatic logic addr_out_of_range(input logic [CPU_ADDR_W-1:0] addr,
                                              input int aw);
      return (addr >> aw) != '0;
   endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side memory strobe bus between the control unit and the responder.
//
// Handshake: a request (MEMBUS for a read, BUSMEM & WE for a write) is the
// "valid"; the requester holds it stable until MEM_READY, the one-cycle
// "ready" completion pulse. Withdrawing a request before MEM_READY aborts
// it. After MEM_READY both MEMBUS and BUSMEM must be seen low for at least
// one cycle before the next request is accepted.
interface mem_responder_if;
   import mem_pkg::*;

   logic [CPU_ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0]     DBUS_IN;
   logic                  MEMBUS;
   logic                  BUSMEM;
   logic                  WE;
   logic [DATA_W-1:0]     DBUS_OUT;
   logic                  DBUS_OE;
   logic                  MEM_READY;
   logic                  MEM_ERR;

   modport master (
      output ADDR, DBUS_IN, MEMBUS, BUSMEM, WE,
      input  DBUS_OUT, DBUS_OE, MEM_READY, MEM_ERR
   );

   modport slave (
      input  ADDR, DBUS_IN, MEMBUS, BUSMEM, WE,
      output DBUS_OUT, DBUS_OE, MEM_READY, MEM_ERR
   );
endinterface

// File: rtl/mem_array.sv
// Single-port byte RAM, synchronous write and registered synchronous read.
// Only the read register is reset; the storage itself keeps its contents.
module mem_array
   import mem_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Storage write port
   always_ff @(posedge clk) begin
      if (we) mem_q[addr] <= wdata;
   end

   // Registered read port, cleared by reset
   always_ff @(posedge clk) begin
      if (rst)     rdata_q <= '0;
      else if (re) rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read or write at a time from the CPU
// strobes, inserts WAIT_CYCLES wait states, then pulses MEM_READY. Flags
// simultaneous MEMBUS/BUSMEM and out-of-range addresses on MEM_ERR.
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              CLK,
   input  logic              CLEAR,
   mem_responder_if.slave    bus,
   output state_e            dbg_state
);
   state_e              state_q, state_d;
   kind_e               kind_q, kind_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                oor_q, oor_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                ready_q, ready_d;
   logic                err_q, err_d;
   logic                oor_rd_q, oor_rd_d;
   logic                arr_we, arr_re, req_held;
   logic [DATA_W-1:0]   arr_rdata;

   // Next-state, latch and array-strobe logic for the access FSM
   always_comb begin
      state_d  = state_q;
      kind_d   = kind_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      oor_d    = oor_q;
      wdata_d  = wdata_q;
      oor_rd_d = oor_rd_q;
      ready_d  = 1'b0;
      err_d    = 1'b0;
      arr_we   = 1'b0;
      arr_re   = 1'b0;
      req_held = (kind_q == READ) ? bus.MEMBUS : (bus.BUSMEM && bus.WE);
      case (state_q)
         IDLE: begin
            if (bus.MEMBUS && bus.BUSMEM) begin
               err_d = 1'b1;
            end else if (bus.MEMBUS || (bus.BUSMEM && bus.WE)) begin
               kind_d  = bus.MEMBUS ? READ : WRITE;
               addr_d  = bus.ADDR[ADDR_W-1:0];
               oor_d   = addr_out_of_range(bus.ADDR, ADDR_W);
               wdata_d = bus.DBUS_IN;
               cnt_d   = 4'(WAIT_CYCLES);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (!req_held) begin
               state_d = IDLE;
            end else if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = DONE;
               ready_d = 1'b1;
               err_d   = oor_q;
               if (kind_q == READ) begin
                  arr_re   = !oor_q;
                  oor_rd_d = oor_q;
               end else begin
                  // A write racing with CLEAR must not land in the array
                  arr_we = !oor_q && !CLEAR;
               end
            end
         end
         DONE:    state_d = RELEASE;
         RELEASE: if (!bus.MEMBUS && !bus.BUSMEM) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, latches and registered completion/error pulses
   always_ff @(posedge CLK) begin
      if (CLEAR) begin
         state_q  <= IDLE;
         kind_q   <= READ;
         cnt_q    <= '0;
         addr_q   <= '0;
         oor_q    <= 1'b0;
         wdata_q  <= '0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
         oor_rd_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         kind_q   <= kind_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         oor_q    <= oor_d;
         wdata_q  <= wdata_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
         oor_rd_q <= oor_rd_d;
      end
   end

   mem_array #(.ADDR_W(ADDR_W)) u_array (
      .clk   (CLK),
      .rst   (CLEAR),
      .we    (arr_we),
      .re    (arr_re),
      .addr  (addr_q),
      .wdata (wdata_q),
      .rdata (arr_rdata)
   );

   // Out-of-range reads return zero; drive enable follows MEMBUS directly
   assign bus.DBUS_OUT  = oor_rd_q ? '0 : arr_rdata;
   assign bus.DBUS_OE   = ((state_q == DONE) || (state_q == RELEASE)) &&
                          (kind_q == READ) && bus.MEMBUS;
   assign bus.MEM_READY = ready_q;
   assign bus.MEM_ERR   = err_q;
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (WAIT_CYCLES 1, 0, 3),
// a table of accesses on the first, and hand sequences for corner cases.
module tb_mem_responder;
   import mem_pkg::*;

   logic          CLK = 1'b0;
   logic          clear_a  [3];
   logic [15:0]   addr_a   [3];
   logic [7:0]    din_a    [3];
   logic          membus_a [3];
   logic          busmem_a [3];
   logic          we_a     [3];
   logic [7:0]    dout_a   [3];
   logic          oe_a     [3];
   logic          ready_a  [3];
   logic          err_a    [3];
   state_e        state_a  [3];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      mem_responder_if bus ();
      assign bus.ADDR    = addr_a[g];
      assign bus.DBUS_IN = din_a[g];
      assign bus.MEMBUS  = membus_a[g];
      assign bus.BUSMEM  = busmem_a[g];
      assign bus.WE      = we_a[g];
      assign dout_a[g]   = bus.DBUS_OUT;
      assign oe_a[g]     = bus.DBUS_OE;
      assign ready_a[g]  = bus.MEM_READY;
      assign err_a[g]    = bus.MEM_ERR;
      mem_responder #(
         .ADDR_W      (10),
         .WAIT_CYCLES (g == 0 ? 1 : (g == 1 ? 0 : 3))
      ) dut (
         .CLK       (CLK),
         .CLEAR     (clear_a[g]),
         .bus       (bus),
         .dbg_state (state_a[g])
      );
   end

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  exp_rd;
      bit          exp_err;
   } vec_t;

   vec_t tab [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #2;
   endtask

   task automatic idle_inputs(input int d);
      membus_a[d] = 1'b0;
      busmem_a[d] = 1'b0;
      we_a[d]     = 1'b0;
   endtask

   // Full access: hold the request until MEM_READY (bounded), then release.
   // lat counts clock edges from the accepting edge (1) to the ready edge.
   task automatic do_access(input int d, input bit wr, input logic [15:0] a,
                            input logic [7:0] wd, output int lat,
                            output logic [7:0] rd, output logic err, output logic oe);
      bit got = 0;
      lat = 0; rd = 'x; err = 'x; oe = 'x;
      addr_a[d]   = a;
      din_a[d]    = wd;
      membus_a[d] = !wr;
      busmem_a[d] = wr;
      we_a[d]     = wr;
      for (int k = 1; k <= 30 && !got; k++) begin
         tick();
         if (ready_a[d]) begin
            got = 1; lat = k; rd = dout_a[d]; err = err_a[d]; oe = oe_a[d];
         end
      end
      idle_inputs(d);
      tick();
      tick();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int lat;
      logic [7:0] rd;
      logic err, oe;
      int n_rdy, n_err;

      tab[0]  = '{1, 16'h0012, 8'hA5, 8'h00, 0};
      tab[1]  = '{0, 16'h0012, 8'h00, 8'hA5, 0};
      tab[2]  = '{1, 16'h0000, 8'h3C, 8'h00, 0};
      tab[3]  = '{1, 16'h03FF, 8'h7E, 8'h00, 0};
      tab[4]  = '{0, 16'h03FF, 8'h00, 8'h7E, 0};
      tab[5]  = '{1, 16'h8000, 8'h11, 8'h00, 1};
      tab[6]  = '{0, 16'h0000, 8'h00, 8'h3C, 0};
      tab[7]  = '{0, 16'h8000, 8'h00, 8'h00, 1};
      tab[8]  = '{1, 16'h0400, 8'h22, 8'h00, 1};
      tab[9]  = '{0, 16'h0000, 8'h00, 8'h3C, 0};
      tab[10] = '{0, 16'h0012, 8'h00, 8'hA5, 0};

      // Reset all instances
      for (int d = 0; d < 3; d++) begin
         clear_a[d] = 1'b1; addr_a[d] = '0; din_a[d] = '0;
         idle_inputs(d);
      end
      repeat (3) tick();
      for (int d = 0; d < 3; d++) clear_a[d] = 1'b0;
      tick();
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("reset_ready[%0d]", d), 32'(ready_a[d]), 32'd0);
         chk($sformatf("reset_err[%0d]", d),   32'(err_a[d]),   32'd0);
         chk($sformatf("reset_oe[%0d]", d),    32'(oe_a[d]),    32'd0);
         chk($sformatf("reset_dout[%0d]", d),  32'(dout_a[d]),  32'd0);
         chk($sformatf("reset_state[%0d]", d), 32'(state_a[d]), 32'(IDLE));
      end

      // Table of accesses on the WAIT_CYCLES=1 instance: ready 3 edges in
      for (int i = 0; i < 11; i++) begin
         do_access(0, tab[i].wr, tab[i].addr, tab[i].wdata, lat, rd, err, oe);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
         chk($sformatf("vec%0d_err", i), 32'(err), 32'(tab[i].exp_err));
         chk($sformatf("vec%0d_oe", i), 32'(oe), 32'(!tab[i].wr));
         if (!tab[i].wr) chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tab[i].exp_rd));
      end

      // WAIT_CYCLES=0: ready 2 edges in; held MEMBUS gives a single pulse
      do_access(1, 1'b1, 16'h0055, 8'h9C, lat, rd, err, oe);
      chk("wc0_write_latency", 32'(lat), 32'd2);
      addr_a[1] = 16'h0055; membus_a[1] = 1'b1;
      tick();
      chk("wc0_read_not_yet", 32'(ready_a[1]), 32'd0);
      tick();
      chk("wc0_read_ready", 32'(ready_a[1]), 32'd1);
      chk("wc0_read_data", 32'(dout_a[1]), 32'h9C);
      chk("wc0_read_oe", 32'(oe_a[1]), 32'd1);
      n_rdy = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         n_rdy += int'(ready_a[1]);
         chk($sformatf("wc0_hold_oe%0d", k), 32'(oe_a[1]), 32'd1);
         chk($sformatf("wc0_hold_data%0d", k), 32'(dout_a[1]), 32'h9C);
      end
      chk("wc0_hold_no_retrigger", 32'(n_rdy), 32'd0);
      membus_a[1] = 1'b0;
      #1;
      chk("wc0_oe_drops_with_membus", 32'(oe_a[1]), 32'd0);
      tick();
      chk("wc0_back_to_idle", 32'(state_a[1]), 32'(IDLE));

      // Protocol violation: MEMBUS and BUSMEM together for 3 cycles
      addr_a[0] = 16'h0012; din_a[0] = 8'hFF;
      membus_a[0] = 1'b1; busmem_a[0] = 1'b1; we_a[0] = 1'b1;
      n_rdy = 0; n_err = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k == 2) idle_inputs(0);
         n_rdy += int'(ready_a[0]);
         n_err += int'(err_a[0]);
      end
      chk("viol_err_cycles", 32'(n_err), 32'd3);
      chk("viol_no_ready", 32'(n_rdy), 32'd0);
      do_access(0, 1'b0, 16'h0012, 8'h00, lat, rd, err, oe);
      chk("viol_mem_unchanged", 32'(rd), 32'hA5);

      // WAIT_CYCLES=3: write aborted by dropping WE
      do_access(2, 1'b1, 16'h0020, 8'h44, lat, rd, err, oe);
      chk("wc3_write_latency", 32'(lat), 32'd5);
      addr_a[2] = 16'h0020; din_a[2] = 8'h99;
      busmem_a[2] = 1'b1; we_a[2] = 1'b1;
      tick();
      we_a[2] = 1'b0;
      n_rdy = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (k == 2) busmem_a[2] = 1'b0;
         n_rdy += int'(ready_a[2]);
      end
      chk("abort_no_ready", 32'(n_rdy), 32'd0);
      chk("abort_idle", 32'(state_a[2]), 32'(IDLE));
      do_access(2, 1'b0, 16'h0020, 8'h00, lat, rd, err, oe);
      chk("abort_read_latency", 32'(lat), 32'd5);
      chk("abort_location_kept", 32'(rd), 32'h44);

      // CLEAR during the WAIT of a write
      do_access(2, 1'b1, 16'h0030, 8'h5A, lat, rd, err, oe);
      addr_a[2] = 16'h0030; din_a[2] = 8'hC3;
      busmem_a[2] = 1'b1; we_a[2] = 1'b1;
      tick();
      tick();
      clear_a[2] = 1'b1;
      tick();
      clear_a[2] = 1'b0;
      idle_inputs(2);
      #1;
      chk("clear_ready", 32'(ready_a[2]), 32'd0);
      chk("clear_err", 32'(err_a[2]), 32'd0);
      chk("clear_oe", 32'(oe_a[2]), 32'd0);
      chk("clear_dout", 32'(dout_a[2]), 32'd0);
      chk("clear_state", 32'(state_a[2]), 32'(IDLE));
      tick();
      do_access(2, 1'b0, 16'h0030, 8'h00, lat, rd, err, oe);
      chk("clear_read_latency", 32'(lat), 32'd5);
      chk("clear_location_kept", 32'(rd), 32'h5A);
      chk("clear_read_err", 32'(err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
